// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - instruction memory loader and fetch controller; IMEM_CTRL_CHECKSUM_EN adds the ld_sum checksum output
module imem_ctrl #(
  parameter int AW   = 10,
  parameter int LENW = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_start,
  input  logic [31:0]     ld_base,
  input  logic [LENW-1:0] ld_len,
  input  logic            ld_valid,
  input  logic [31:0]     ld_data,
  output logic            ld_ready,
  output logic            ld_busy,
  output logic            ld_done,
  output logic            ld_err,
`ifdef IMEM_CTRL_CHECKSUM_EN
  output logic [31:0]     ld_sum,
`endif
  input  logic            fetch_req,
  input  logic [31:0]     fetch_addr,
  output logic            fetch_gnt,
  output logic            fetch_valid,
  output logic [31:0]     fetch_data,
  output logic            fetch_err,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_din,
  output logic            mem_we,
  input  logic [31:0]     mem_dout
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  // Memory size in bytes and the last legal word address, widened so no compare can overflow.
  localparam logic [33:0] MEM_BYTES  = 34'd1 << AW;
  localparam logic [32:0] FETCH_LAST = (33'd1 << AW) - 33'd4;

  state_t          state_q, state_d;
  logic [31:0]     ptr_q, ptr_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic            ld_done_q, ld_done_d;
  logic            ld_err_q, ld_err_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic [31:0]     fetch_data_q, fetch_data_d;
  logic            fetch_err_q, fetch_err_d;
`ifdef IMEM_CTRL_CHECKSUM_EN
  logic [31:0]     sum_q, sum_d;
`endif

  logic [33:0] ld_end;
  logic        ld_ok;
  logic        fetch_bad;
  logic        in_idle;
  logic        in_load;
  logic        accept;
  logic        word_wr;

  // Request qualification, grant and memory-port steering; a load always takes priority over fetches.
  always_comb begin
    in_idle   = (state_q == IDLE);
    in_load   = (state_q == LOAD);
    ld_end    = {2'b00, ld_base} + {{(32-LENW){1'b0}}, ld_len, 2'b00};
    ld_ok     = (ld_len != '0) && (ld_base[1:0] == 2'b00) && (ld_end <= MEM_BYTES);
    fetch_bad = (fetch_addr[1:0] != 2'b00) || ({1'b0, fetch_addr} > FETCH_LAST);
    accept    = in_idle && ld_start && ld_ok;
    fetch_gnt = in_idle && fetch_req && !ld_start;
    // A word arriving in the reset cycle is dropped so an aborted load never writes late.
    word_wr   = in_load && ld_valid && !reset;
    mem_we    = word_wr;
    mem_din   = in_load ? ld_data : 32'd0;
    if (in_load) begin
      mem_addr = ptr_q;
    end else if (fetch_gnt) begin
      mem_addr = fetch_addr;
    end else begin
      mem_addr = 32'd0;
    end
    ld_ready = in_load;
    ld_busy  = in_load;
  end

  // Next-state logic for the load sequencer and the one-deep fetch response register.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    ld_done_d     = 1'b0;
    ld_err_d      = in_idle && ld_start && !ld_ok;
    fetch_valid_d = fetch_gnt;
    fetch_err_d   = fetch_gnt && fetch_bad;
    fetch_data_d  = (fetch_gnt && !fetch_bad) ? mem_dout : 32'd0;
`ifdef IMEM_CTRL_CHECKSUM_EN
    sum_d         = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          ptr_d   = ld_base;
          cnt_d   = ld_len;
`ifdef IMEM_CTRL_CHECKSUM_EN
          sum_d   = 32'd0;
`endif
        end
      end
      LOAD: begin
        if (ld_valid) begin
          ptr_d = ptr_q + 32'd4;
          cnt_d = cnt_q - LENW'(1);
`ifdef IMEM_CTRL_CHECKSUM_EN
          sum_d = sum_q + ld_data;
`endif
          if (cnt_q == LENW'(1)) begin
            state_d   = DONE;
            ld_done_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything, abandoning any load in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= 32'd0;
      cnt_q         <= '0;
      ld_done_q     <= 1'b0;
      ld_err_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= 32'd0;
      fetch_err_q   <= 1'b0;
`ifdef IMEM_CTRL_CHECKSUM_EN
      sum_q         <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      ld_done_q     <= ld_done_d;
      ld_err_q      <= ld_err_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      fetch_err_q   <= fetch_err_d;
`ifdef IMEM_CTRL_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign ld_done     = ld_done_q;
  assign ld_err      = ld_err_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_err   = fetch_err_q;
`ifdef IMEM_CTRL_CHECKSUM_EN
  assign ld_sum      = sum_q;
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - randomized bench for imem_ctrl against a word-level behavioural model
`timescale 1ns/1ps
module tb_imem_ctrl;
  localparam int AW     = 10;
  localparam int LENW   = 9;
  localparam int NWORDS = (1 << AW) / 4;
  localparam logic [63:0] MEMB = 64'd1 << AW;

  logic            clk = 1'b0;
  logic            reset;
  logic            ld_start;
  logic [31:0]     ld_base;
  logic [LENW-1:0] ld_len;
  logic            ld_valid;
  logic [31:0]     ld_data;
  logic            ld_ready, ld_busy, ld_done, ld_err;
  logic            fetch_req;
  logic [31:0]     fetch_addr;
  logic            fetch_gnt, fetch_valid, fetch_err;
  logic [31:0]     fetch_data;
  logic [31:0]     mem_addr, mem_din, mem_dout;
  logic            mem_we;
`ifdef IMEM_CTRL_CHECKSUM_EN
  logic [31:0]     ld_sum;
`endif

  always #5 clk = ~clk;

  imem_ctrl #(.AW(AW), .LENW(LENW)) dut (
    .clk(clk), .reset(reset),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err),
`ifdef IMEM_CTRL_CHECKSUM_EN
    .ld_sum(ld_sum),
`endif
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  int checks   = 0;
  int failures = 0;
  int wcount   = 0;

  logic [31:0] tmem [NWORDS];
  logic [31:0] gmem [NWORDS];

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory attached to the DUT: combinational read, write on the rising edge.
  assign mem_dout = tmem[mem_addr[AW-1:2]];
  initial begin
    for (int i = 0; i < NWORDS; i++) tmem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_we === 1'b1) begin
        tmem[mem_addr[AW-1:2]] <= mem_din;
        wcount++;
      end
    end
  end

  // Behavioural model: tracks load progress in words and an ideal memory image.
  bit          m_on, m_load, m_done, m_err, m_fv, m_ferr;
  logic [31:0] m_fdata, m_ptr, m_sum;
  int          m_left;

  initial begin
    bit          idle, gnt, legal, bad, exp_we;
    logic [31:0] exp_addr;
    logic [63:0] endb;
    for (int i = 0; i < NWORDS; i++) gmem[i] = init_word(i);
    m_on = 0;
    forever begin
      @(negedge clk);
      idle   = !m_load && !m_done;
      gnt    = idle && fetch_req && !ld_start;
      exp_we = m_load && ld_valid && !reset;
      exp_addr = m_load ? m_ptr : (gnt ? fetch_addr : 32'd0);
      if (m_on) begin
        chk("ld_ready", ld_ready, m_load);
        chk("ld_busy", ld_busy, m_load);
        chk("ld_done", ld_done, m_done);
        chk("ld_err", ld_err, m_err);
        chk("fetch_gnt", fetch_gnt, gnt);
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        if (exp_we) chk("mem_din", mem_din, ld_data);
        chk("fetch_valid", fetch_valid, m_fv);
        if (m_fv) begin
          chk("fetch_data", fetch_data, m_fdata);
          chk("fetch_err", fetch_err, m_ferr);
        end
`ifdef IMEM_CTRL_CHECKSUM_EN
        chk("ld_sum", ld_sum, m_sum);
`endif
      end
      endb  = 64'(ld_base) + 64'(ld_len) * 64'd4;
      legal = (ld_base[1:0] == 2'b00) && (ld_len != '0) && (endb <= MEMB);
      bad   = (fetch_addr[1:0] != 2'b00) || (64'(fetch_addr) > MEMB - 64'd4);
      if (reset) begin
        m_load = 0; m_done = 0; m_err = 0; m_fv = 0; m_ferr = 0;
        m_fdata = 0; m_ptr = 0; m_left = 0; m_sum = 0; m_on = 1;
      end else begin
        m_err   = idle && ld_start && !legal;
        m_fv    = gnt;
        m_ferr  = gnt && bad;
        m_fdata = (gnt && !bad) ? gmem[fetch_addr[AW-1:2]] : 32'd0;
        if (idle && ld_start && legal) begin
          m_load = 1; m_ptr = ld_base; m_left = int'(ld_len); m_sum = 0;
        end else if (m_load) begin
          if (ld_valid) begin
            gmem[m_ptr[AW-1:2]] = ld_data;
            m_sum  = m_sum + ld_data;
            m_ptr  = m_ptr + 32'd4;
            m_left = m_left - 1;
            if (m_left == 0) begin
              m_load = 0;
              m_done = 1;
            end
          end
        end else if (m_done) begin
          m_done = 0;
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] base, input int len, input int gap,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [31:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    ld_start = 1; ld_base = base; ld_len = LENW'(len);
    nxt();
    ld_start = 0;
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gap; g++) begin
        ld_valid = 0;
        nxt();
      end
      ld_valid = 1; ld_data = w[i];
      nxt();
    end
    ld_valid = 0;
    chk("done_pulse", ld_done, 1'b1);
    chk("done_ready", ld_ready, 1'b0);
    nxt();
    chk("done_clear", ld_done, 1'b0);
  endtask

  initial begin
    int          wb;
    int          r;
    reset = 1; ld_start = 0; ld_base = 0; ld_len = 0; ld_valid = 0; ld_data = 0;
    fetch_req = 0; fetch_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_busy", ld_busy, 1'b0);
    chk("rst_done", ld_done, 1'b0);
    chk("rst_err", ld_err, 1'b0);
    chk("rst_fvalid", fetch_valid, 1'b0);
    chk("rst_fdata", fetch_data, 32'd0);
    chk("rst_ferr", fetch_err, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'd0);
`ifdef IMEM_CTRL_CHECKSUM_EN
    chk("rst_sum", ld_sum, 32'd0);
`endif
    nxt();

    // Back-to-back three-word load at 0x10.
    wb = wcount;
    do_load(32'h10, 3, 0, 32'h11111111, 32'h22222222, 32'h33333333);
    chk("wr_count_b2b", 32'(wcount - wb), 32'd3);
    chk("mem_10", tmem[4], 32'h11111111);
    chk("mem_14", tmem[5], 32'h22222222);
    chk("mem_18", tmem[6], 32'h33333333);
    chk("model_14", gmem[5], 32'h22222222);
`ifdef IMEM_CTRL_CHECKSUM_EN
    chk("sum_b2b", ld_sum, 32'h66666666);
`endif

    // Same load with two idle cycles before each word.
    wb = wcount;
    do_load(32'h10, 3, 2, 32'h11111111, 32'h22222222, 32'h33333333);
    chk("wr_count_gap", 32'(wcount - wb), 32'd3);
    chk("mem_18_gap", tmem[6], 32'h33333333);

    // Rejected loads: overflow past the top, unaligned base, zero length.
    wb = wcount;
    ld_start = 1; ld_base = 32'h3FC; ld_len = 2; nxt(); ld_start = 0;
    chk("err_top", ld_err, 1'b1);
    chk("busy_top", ld_busy, 1'b0);
    ld_start = 1; ld_base = 32'h2; ld_len = 1; nxt(); ld_start = 0;
    chk("err_unal", ld_err, 1'b1);
    ld_start = 1; ld_base = 32'h20; ld_len = 0; nxt(); ld_start = 0;
    chk("err_len0", ld_err, 1'b1);
    nxt();
    chk("err_clear", ld_err, 1'b0);
    chk("wr_count_rej", 32'(wcount - wb), 32'd0);

    // A load ending exactly at the top of memory is legal.
    do_load(32'h3F8, 2, 1, 32'hBEEF0001, 32'hBEEF0002, 32'h0);
    chk("mem_3fc", tmem[255], 32'hBEEF0002);

    // Fetches: good, unaligned, out of range, last word; one per cycle.
    fetch_req = 1; fetch_addr = 32'h10; #1;
    chk("gnt_10", fetch_gnt, 1'b1);
    chk("maddr_10", mem_addr, 32'h10);
    nxt(); fetch_addr = 32'h12;
    chk("fv_10", fetch_valid, 1'b1);
    chk("fd_10", fetch_data, 32'h11111111);
    chk("fe_10", fetch_err, 1'b0);
    nxt(); fetch_addr = 32'h400;
    chk("fe_12", fetch_err, 1'b1);
    chk("fd_12", fetch_data, 32'd0);
    nxt(); fetch_addr = 32'h3FC;
    chk("fe_400", fetch_err, 1'b1);
    nxt(); fetch_req = 0;
    chk("fe_3fc", fetch_err, 1'b0);
    chk("fd_3fc", fetch_data, 32'hBEEF0002);
    nxt();
    chk("fv_idle", fetch_valid, 1'b0);

    // Load start beats a same-cycle fetch; the fetch waits out the load.
    ld_start = 1; ld_base = 32'h40; ld_len = 2; fetch_req = 1; fetch_addr = 32'h10; #1;
    chk("gnt_start", fetch_gnt, 1'b0);
    nxt(); ld_start = 0; #1;
    chk("busy_pri", ld_busy, 1'b1);
    chk("gnt_load", fetch_gnt, 1'b0);
    ld_valid = 1; ld_data = 32'hCAFE0001; nxt();
    ld_data = 32'hCAFE0002; nxt();
    ld_valid = 0; #1;
    chk("done_pri", ld_done, 1'b1);
    chk("gnt_done", fetch_gnt, 1'b0);
    nxt(); #1;
    chk("gnt_after", fetch_gnt, 1'b1);
    nxt(); fetch_req = 0;
    chk("fv_pri", fetch_valid, 1'b1);
    chk("fd_pri", fetch_data, 32'h11111111);
    nxt();

    // Reset after the first of three words, with a word offered in the reset cycle.
    wb = wcount;
    ld_start = 1; ld_base = 32'h100; ld_len = 3; nxt(); ld_start = 0;
    ld_valid = 1; ld_data = 32'hD00D0000; nxt();
    ld_data = 32'hD00D0001; reset = 1; nxt();
    reset = 0; ld_valid = 0;
    chk("abort_busy", ld_busy, 1'b0);
    chk("abort_done", ld_done, 1'b0);
    chk("abort_wr", 32'(wcount - wb), 32'd1);
    fetch_req = 1; fetch_addr = 32'h100; nxt(); fetch_addr = 32'h104;
    chk("abort_w0", fetch_data, 32'hD00D0000);
    nxt(); fetch_addr = 32'h108;
    chk("abort_w1", fetch_data, init_word(65));
    nxt(); fetch_req = 0;
    chk("abort_w2", fetch_data, init_word(66));
    nxt();

    // Randomized traffic checked cycle by cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 399) == 0);
      ld_start = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 9);
      if (r == 0) ld_base = $urandom;
      else if (r == 1) ld_base = 32'($urandom_range(0, 1023));
      else ld_base = 32'($urandom_range(0, 255)) << 2;
      r = $urandom_range(0, 9);
      if (r == 0) ld_len = LENW'($urandom);
      else if (r == 1) ld_len = '0;
      else ld_len = LENW'($urandom_range(1, 6));
      ld_valid = ($urandom_range(0, 9) < 6);
      ld_data  = $urandom;
      fetch_req = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      if (r == 0) fetch_addr = $urandom;
      else if (r == 1) fetch_addr = 32'($urandom_range(0, 1027));
      else fetch_addr = 32'($urandom_range(0, 255)) << 2;
      nxt();
    end
    reset = 0; ld_start = 0; ld_valid = 0; fetch_req = 0;
    repeat (4) nxt();
    for (int i = 0; i < NWORDS; i++) chk("mem_image", tmem[i], gmem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL have parameter AW, default 10: byte-address width of the attached instruction memory (2**AW bytes).
REQ-002 SHALL have parameter LENW, default 9: width of the load word-count port.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ld_start  input  1  one-cycle request to begin a program load.
REQ-006 SHALL have port ld_base  input  32  byte start address of the load.
REQ-007 SHALL have port ld_len  input  LENW  number of 32-bit words to load.
REQ-008 SHALL have ports ld_valid input 1 / ld_data input 32 / ld_ready output 1: loader word stream, with a valid/ready handshake.
REQ-009 SHALL have ports ld_busy output 1, ld_done output 1, ld_err output 1: load status.
REQ-010 SHALL have ports fetch_req input 1 / fetch_addr input 32 / fetch_gnt output 1: fetch request and grant.
REQ-011 SHALL have ports fetch_valid output 1, fetch_data output 32, fetch_err output 1: fetch response.
REQ-012 SHALL have ports mem_addr output 32, mem_din output 32, mem_we output 1, mem_dout input 32: memory side; reads are combinational, words are little-endian bytes at mem_addr..+3.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, DONE; reset state IDLE.
REQ-014 IDLE: accepted ld_start SHALL win over a same-cycle fetch_req; in that cycle fetch_gnt=0.
REQ-015 ld_start SHALL be accepted only if ld_len!=0, ld_base[1:0]==0 and ld_base+4*ld_len <= 2**AW; on acceptance it latches ptr=ld_base, cnt=ld_len and moves to LOAD.
REQ-016 A rejected ld_start in IDLE SHALL pulse ld_err for one cycle the following cycle, stay in IDLE, and write nothing.
REQ-017 LOAD: ld_ready=1, ld_busy=1; mem_we=ld_valid (combinational), mem_addr=ptr, mem_din=ld_data.
REQ-018 Each ld_valid&&ld_ready cycle SHALL write one word, then ptr+=4, cnt-=1; when the write with cnt==1 occurs, next state is DONE.
REQ-019 ld_valid=0 in LOAD SHALL stall with no write and no counter change, for any number of cycles.
REQ-020 DONE SHALL last exactly one cycle with ld_done=1, ld_ready=0, ld_busy=0, then return to IDLE.
REQ-021 ld_start in LOAD or DONE SHALL be ignored (no ld_err).
REQ-022 IDLE with fetch_req and no ld_start: fetch_gnt=1 combinationally; mem_addr=fetch_addr; mem_we=0.
REQ-023 A granted fetch SHALL respond in the next cycle with fetch_valid=1 and fetch_data=mem_dout registered at the grant edge; latency exactly 1, one fetch per cycle sustained.
REQ-024 A granted fetch with fetch_addr[1:0]!=0 or fetch_addr > 2**AW-4 SHALL respond with fetch_valid=1, fetch_err=1, fetch_data=0.
REQ-025 fetch_gnt SHALL be 0 in LOAD and DONE; fetch_valid=0 in any cycle not following a grant.
REQ-026 When idle and not fetching, mem_addr SHALL be 0 and mem_we 0; mem_we SHALL never be 1 outside LOAD.

Reset
REQ-027 Reset SHALL force state IDLE, ptr=0, cnt=0, and all registered outputs to 0: fetch_valid, fetch_data, fetch_err, ld_done, ld_err.
REQ-028 Reset during LOAD SHALL abort without ld_done; words already written remain in memory; no write in the reset cycle.

Configuration
REQ-029 With IMEM_CTRL_CHECKSUM_EN defined, output ld_sum (32) SHALL exist: cleared on accepted ld_start, adds each accepted ld_data modulo 2**32, holds after DONE, reset to 0.
REQ-030 Without IMEM_CTRL_CHECKSUM_EN, port ld_sum and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Load base 0x10, len 3, data 0x11111111/0x22222222/0x33333333 back-to-back -> writes at 0x10/0x14/0x18, ld_done one cycle after third write, ld_sum=0x66666666.
REQ-032 Same load with ld_valid deasserted 2 cycles between words -> identical writes, no extra mem_we, ld_done after third word.
REQ-033 ld_start base 0x3FC len 2, and base 0x2 len 1 -> ld_err pulse each, no mem_we, state stays IDLE.
REQ-034 Fetch 0x10 after REQ-031 load -> next cycle fetch_valid=1, fetch_data=0x11111111; fetch 0x12 -> fetch_err=1, data 0; fetch 0x400 -> fetch_err=1.
REQ-035 ld_start and fetch_req same cycle -> fetch_gnt=0, LOAD entered; fetch held until after DONE, then granted.
REQ-036 Reset asserted after 1 of 3 words -> IDLE, no ld_done, word 0 readable by fetch, words 1-2 unchanged.
